// File: rtl/foc_pkg.sv
// rtl/foc_pkg.sv - FOC 4-to-5 codeword table and decode helper shared by encoder and deframer
package foc_pkg;

    localparam int CW_W   = 5;
    localparam int NIB_W  = 4;
    localparam int NUM_CW = 16;

    typedef logic [CW_W-1:0]  cw_t;
    typedef logic [NIB_W-1:0] nib_t;

    typedef struct packed {
        logic illegal;
        nib_t nibble;
    } foc_dec_t;

    // Indexed by nibble value: entry i is the codeword the encoder emits for nibble i.
    localparam cw_t FOC_TABLE [NUM_CW] = '{
        5'b00000, 5'b00100, 5'b00001, 5'b00101,
        5'b00011, 5'b00111, 5'b10011, 5'b10111,
        5'b10000, 5'b10100, 5'b10001, 5'b10101,
        5'b11000, 5'b11100, 5'b11001, 5'b11101
    };

    function automatic foc_dec_t foc_decode(input cw_t cw);
        foc_dec_t r;
        r.illegal = 1'b1;
        r.nibble  = '0;
        for (int i = 0; i < NUM_CW; i++) begin
            if (cw == FOC_TABLE[i]) begin
                r.illegal = 1'b0;
                r.nibble  = NIB_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/foc_dec_5to4.sv
// rtl/foc_dec_5to4.sv - combinational FOC codeword to nibble decoder
module foc_dec_5to4
    import foc_pkg::*;
(
    input  logic [CW_W-1:0]  cw_in,
    output logic [NIB_W-1:0] nibble,
    output logic             illegal
);

    foc_dec_t dec;

    assign dec     = foc_decode(cw_in);
    assign nibble  = dec.nibble;
    assign illegal = dec.illegal;

endmodule

// File: rtl/foc_rx_deframer.sv
// rtl/foc_rx_deframer.sv - FOC receive deframer: decode, pack nibbles into words, registered output
module foc_rx_deframer
    import foc_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int ERR_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CW_W-1:0]          cw_in,
    input  logic                     cw_valid,
    output logic                     cw_ready,
    input  logic                     sync_clr,
    output logic [NIB_W*NIBBLES-1:0] data_out,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic                     data_err,
    output logic [ERR_W-1:0]         err_cnt
);

    localparam int WORD_W = NIB_W * NIBBLES;
    localparam int ACC_W  = WORD_W - NIB_W;
    localparam int CNT_W  = $clog2(NIBBLES);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]        state_q,    state_d;
    logic [CNT_W-1:0]  nib_cnt_q,  nib_cnt_d;
    logic [ACC_W-1:0]  acc_q,      acc_d;
    logic              acc_err_q,  acc_err_d;
    logic [WORD_W-1:0] data_q,     data_d;
    logic              data_err_q, data_err_d;
    logic [ERR_W-1:0]  err_cnt_q,  err_cnt_d;

    logic [NIB_W-1:0]  dec_nib;
    logic              dec_ill;
    logic              accept;
    logic              take;
    logic              last;
    logic [WORD_W-1:0] word_next;

    foc_dec_5to4 u_dec (
        .cw_in   (cw_in),
        .nibble  (dec_nib),
        .illegal (dec_ill)
    );

    assign data_valid = (state_q == ST_FULL);
    assign cw_ready   = !data_valid || data_ready;
    assign data_out   = data_q;
    assign data_err   = data_err_q;
    assign err_cnt    = err_cnt_q;

    // A codeword accepted together with sync_clr is discarded entirely.
    assign accept = cw_valid && cw_ready;
    assign take   = accept && !sync_clr;
    assign last   = take && (nib_cnt_q == LAST_IDX);

    // Accumulator shifts right so the first nibble lands in the low bits of the word.
    assign word_next = {dec_nib, acc_q};

    always_comb begin
        nib_cnt_d  = nib_cnt_q;
        acc_d      = acc_q;
        acc_err_d  = acc_err_q;
        data_d     = data_q;
        data_err_d = data_err_q;
        err_cnt_d  = err_cnt_q;

        if (sync_clr) begin
            nib_cnt_d = '0;
            acc_d     = '0;
            acc_err_d = 1'b0;
        end else if (take) begin
            if (last) begin
                nib_cnt_d  = '0;
                acc_d      = '0;
                acc_err_d  = 1'b0;
                data_d     = word_next;
                data_err_d = acc_err_q | dec_ill;
            end else begin
                nib_cnt_d = nib_cnt_q + 1'b1;
                acc_d     = word_next[WORD_W-1:NIB_W];
                acc_err_d = acc_err_q | dec_ill;
            end
        end

        if (take && dec_ill && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (last)            state_d = ST_FULL;
            ST_FULL:  if (data_ready && !last) state_d = ST_EMPTY;
            default:                       state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            nib_cnt_q  <= '0;
            acc_q      <= '0;
            acc_err_q  <= 1'b0;
            data_q     <= '0;
            data_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            nib_cnt_q  <= nib_cnt_d;
            acc_q      <= acc_d;
            acc_err_q  <= acc_err_d;
            data_q     <= data_d;
            data_err_q <= data_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_foc_rx_deframer.sv
// tb/tb_foc_rx_deframer.sv - scoreboard bench for foc_rx_deframer with default parameters
module tb_foc_rx_deframer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  cw_in;
    logic        cw_valid;
    logic        cw_ready;
    logic        sync_clr;
    logic [15:0] data_out;
    logic        data_valid;
    logic        data_ready;
    logic        data_err;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;
    int stalls = 0;

    logic [16:0] exp_q[$];
    logic [15:0] m_acc;
    int          m_cnt;
    logic        m_err;
    int          m_errcnt;
    logic [16:0] last_pushed;

    always #5 clk = ~clk;

    foc_rx_deframer #(.NIBBLES(4), .ERR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cw_in      (cw_in),
        .cw_valid   (cw_valid),
        .cw_ready   (cw_ready),
        .sync_clr   (sync_clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_err   (data_err),
        .err_cnt    (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ref_dec(input logic [4:0] cw);
        case (cw)
            5'b00000: return 5'h00;  5'b00100: return 5'h01;
            5'b00001: return 5'h02;  5'b00101: return 5'h03;
            5'b00011: return 5'h04;  5'b00111: return 5'h05;
            5'b10011: return 5'h06;  5'b10111: return 5'h07;
            5'b10000: return 5'h08;  5'b10100: return 5'h09;
            5'b10001: return 5'h0A;  5'b10101: return 5'h0B;
            5'b11000: return 5'h0C;  5'b11100: return 5'h0D;
            5'b11001: return 5'h0E;  5'b11101: return 5'h0F;
            default:  return 5'h10;
        endcase
    endfunction

    function automatic logic [4:0] ref_enc(input int n);
        logic [4:0] tbl [16] = '{5'b00000, 5'b00100, 5'b00001, 5'b00101,
                                 5'b00011, 5'b00111, 5'b10011, 5'b10111,
                                 5'b10000, 5'b10100, 5'b10001, 5'b10101,
                                 5'b11000, 5'b11100, 5'b11001, 5'b11101};
        return tbl[n];
    endfunction

    task automatic model_reset();
        m_acc = '0;
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    task automatic model_accept(input logic [4:0] cw, input logic clr);
        logic [4:0] d;
        if (clr) begin
            model_reset();
            return;
        end
        d = ref_dec(cw);
        if (d[4] && m_errcnt != 255) m_errcnt++;
        m_acc[4*m_cnt +: 4] = d[3:0];
        m_err = m_err | d[4];
        if (m_cnt == 3) begin
            last_pushed = {m_err, m_acc};
            exp_q.push_back(last_pushed);
            model_reset();
        end else begin
            m_cnt++;
        end
    endtask

    task automatic send(input logic [4:0] cw, input logic clr);
        logic got;
        got      = 1'b0;
        cw_in    = cw;
        cw_valid = 1'b1;
        sync_clr = clr;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (cw_ready) begin
                model_accept(cw, clr);
                got = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        chk("cw_accept_timeout", {31'd0, got}, 32'd1);
        cw_valid = 1'b0;
        sync_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && data_valid && data_ready) begin
            logic [16:0] e;
            chk("word_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("data_out", {16'd0, data_out}, {16'd0, e[15:0]});
                chk("data_err", {31'd0, data_err}, {31'd0, e[16]});
            end
        end
    end

    initial begin
        int s0;
        rst_n      = 1'b0;
        cw_in      = '0;
        cw_valid   = 1'b0;
        sync_clr   = 1'b0;
        data_ready = 1'b1;
        m_errcnt   = 0;
        last_pushed = '0;
        model_reset();
        idle(3);
        rst_n = 1'b1;

        @(negedge clk);
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_data_out", {16'd0, data_out}, 32'd0);
        chk("rst_data_err", {31'd0, data_err}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_cw_ready", {31'd0, cw_ready}, 32'd1);
        @(posedge clk);
        #1;

        // First word and its one-cycle latency.
        send(5'b00100, 1'b0);
        send(5'b00001, 1'b0);
        send(5'b00101, 1'b0);
        chk("pre_last_valid", {31'd0, data_valid}, 32'd0);
        send(5'b00011, 1'b0);
        chk("lat_valid", {31'd0, data_valid}, 32'd1);
        chk("lat_data", {16'd0, data_out}, 32'h4321);
        chk("lat_err", {31'd0, data_err}, 32'd0);

        // Eight back-to-back legal codewords.
        s0 = stalls;
        for (int i = 0; i < 8; i++) send(ref_enc($urandom_range(0, 15)), 1'b0);
        chk("b2b_no_stall", stalls - s0, 32'd0);

        // Illegal second nibble, then a clean word.
        send(5'b00100, 1'b0);
        send(5'b01000, 1'b0);
        send(5'b00001, 1'b0);
        send(5'b00101, 1'b0);
        chk("illegal_err_cnt", {24'd0, err_cnt}, 32'd1);
        for (int i = 0; i < 4; i++) send(ref_enc($urandom_range(0, 15)), 1'b0);
        idle(2);

        // Backpressure: full word held, stalled codeword taken on release.
        data_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(ref_enc($urandom_range(0, 15)), 1'b0);
        cw_in    = 5'b00111;
        cw_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_cw_ready", {31'd0, cw_ready}, 32'd0);
            chk("stall_valid", {31'd0, data_valid}, 32'd1);
            chk("stall_data", {16'd0, data_out}, {16'd0, last_pushed[15:0]});
        end
        @(posedge clk);
        #1;
        data_ready = 1'b1;
        @(negedge clk);
        chk("release_cw_ready", {31'd0, cw_ready}, 32'd1);
        model_accept(5'b00111, 1'b0);
        @(posedge clk);
        #1;
        cw_valid = 1'b0;
        for (int i = 0; i < 3; i++) send(ref_enc($urandom_range(0, 15)), 1'b0);

        // sync_clr drops the partial word and the coincident codeword.
        send(5'b10011, 1'b0);
        send(5'b10111, 1'b0);
        send(5'b11101, 1'b1);
        send(5'b11111, 1'b1);
        chk("sync_err_cnt", {24'd0, err_cnt}, m_errcnt);
        send(5'b11000, 1'b0);
        send(5'b11100, 1'b0);
        send(5'b11001, 1'b0);
        send(5'b10100, 1'b0);
        chk("sync_word", {16'd0, data_out}, 32'h9EDC);

        // Saturation of the illegal-codeword counter.
        for (int i = 0; i < 260; i++) send(5'b01000, 1'b0);
        chk("sat_err_cnt", {24'd0, err_cnt}, 32'hFF);
        chk("sat_model", m_errcnt, 32'd255);
        idle(2);

        // Reset mid-word.
        send(5'b10001, 1'b0);
        send(5'b10101, 1'b0);
        rst_n = 1'b0;
        model_reset();
        m_errcnt = 0;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, data_valid}, 32'd0);
        chk("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("mid_rst_cw_ready", {31'd0, cw_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(5'b00111, 1'b0);
        send(5'b10011, 1'b0);
        send(5'b10111, 1'b0);
        send(5'b10000, 1'b0);
        chk("post_rst_word", {16'd0, data_out}, 32'h8765);

        idle(3);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
